// File: rtl/fb_write_ctrl_pkg.sv
// Shared definitions for the frame-buffer write controller: geometry and FSM states.
package fb_pkg;
   localparam int FB_ADDR_W     = 15;
   localparam int FB_PIX_W      = 2;
   localparam int FB_NUM_PIXELS = 32768;
   localparam int PIX_PER_BYTE  = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN,
      ST_CLEAR,
      ST_DONE
   } fb_state_t;
endpackage

// File: rtl/fb_write_ctrl_if.sv
// Receive strobes, frame-buffer write port and status flags of the write controller.
interface fb_write_ctrl_if
   import fb_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W
);
   logic [7:0]          in_data;
   logic                in_valid;
   logic                in_start;
   logic                in_end;
   logic                clear_req;
   logic [FB_PIX_W-1:0] clear_color;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [FB_PIX_W-1:0] wr_data;
   logic                busy;
   logic                image_complete;
   logic                overflow_err;
   logic                short_err;

   modport master (
      output in_data, in_valid, in_start, in_end, clear_req, clear_color,
      input  wr_en, wr_addr, wr_data, busy, image_complete, overflow_err, short_err
   );

   modport slave (
      input  in_data, in_valid, in_start, in_end, clear_req, clear_color,
      output wr_en, wr_addr, wr_data, busy, image_complete, overflow_err, short_err
   );
endinterface

// File: rtl/fb_write_ctrl_byte_fifo.sv
// Small synchronous byte FIFO; flush may coincide with a push, which then lands as entry 0.
module byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd;
   logic [AW-1:0]    r_wr;
   logic [AW:0]      r_cnt;
   logic             w_push;
   logic             w_pop;
   logic [AW-1:0]    w_wr_idx;

   assign o_full   = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty  = (r_cnt == '0);
   assign o_dout   = r_mem[r_rd];
   assign w_push   = i_push && (i_flush || !o_full);
   assign w_pop    = i_pop && !o_empty && !i_flush;
   assign w_wr_idx = i_flush ? '0 : r_wr;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[w_wr_idx] <= i_din;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_rd  <= '0;
         r_wr  <= w_push ? AW'(1) : '0;
         r_cnt <= w_push ? (AW+1)'(1) : '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         if (w_push && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
         else if (!w_push && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
      end
   end
endmodule

// File: rtl/fb_write_ctrl.sv
// Frame-buffer write sequencer: buffers UART bytes, unpacks 4 pixels per byte MSB-first,
// writes them at sequential addresses, and performs bulk frame clears.
module fb_write_ctrl
   import fb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int PIX_W      = FB_PIX_W,
   parameter int NUM_PIXELS = FB_NUM_PIXELS,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   fb_write_ctrl_if.slave bus
);
   localparam int              SH_W     = 8 - PIX_W;
   localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(NUM_PIXELS);
   localparam logic [ADDR_W:0] BYTE_MAX = (ADDR_W+1)'(NUM_PIXELS / PIX_PER_BYTE);
   localparam logic [1:0]      REM_INIT = 2'(PIX_PER_BYTE - 1);

   fb_state_t         r_state;
   fb_state_t         w_next;
   logic [ADDR_W:0]   r_cnt;
   logic [ADDR_W:0]   r_bytes;
   logic [SH_W-1:0]   r_shift;
   logic [1:0]        r_rem;
   logic [PIX_W-1:0]  r_color;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [PIX_W-1:0]  r_wr_data;
   logic              r_complete;
   logic              r_ovf;
   logic              r_short;

   logic              w_active;
   logic              w_full;
   logic              w_empty;
   logic [7:0]        w_dout;
   logic              w_push;
   logic              w_drop;
   logic              w_pop;
   logic              w_wr;
   logic [PIX_W-1:0]  w_px;
   logic              w_enter_clear;
   logic              w_to_done;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (bus.in_start),
      .i_din   (bus.in_data),
      .o_dout  (w_dout),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      w_push        = 1'b0;
      w_drop        = 1'b0;
      w_pop         = 1'b0;
      w_wr          = 1'b0;
      w_px          = '0;
      w_enter_clear = 1'b0;
      w_to_done     = 1'b0;
      w_active      = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
      if (bus.in_start) begin
         // start wins in every state; a same-cycle byte becomes byte 0 of the new image
         w_next = ST_LOAD;
         w_push = bus.in_valid;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (bus.clear_req) begin
                  w_next        = ST_CLEAR;
                  w_enter_clear = 1'b1;
               end
            end
            ST_LOAD: begin
               w_push = bus.in_valid && !w_full && (r_bytes < BYTE_MAX);
               w_drop = bus.in_valid && !w_push;
               if (bus.in_end) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
               if (w_empty && (r_rem == '0)) begin
                  w_next    = ST_DONE;
                  w_to_done = 1'b1;
               end
            end
            ST_CLEAR: begin
               if (r_cnt == CNT_FULL) begin
                  w_next = ST_IDLE;
               end else begin
                  w_wr = 1'b1;
                  w_px = r_color;
               end
            end
            default: w_next = ST_IDLE;
         endcase
         if (w_active && (r_cnt != CNT_FULL)) begin
            if (r_rem != '0) begin
               w_wr = 1'b1;
               w_px = r_shift[SH_W-1 -: PIX_W];
            end else if (!w_empty) begin
               w_pop = 1'b1;
               w_wr  = 1'b1;
               w_px  = w_dout[7 -: PIX_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt      <= '0;
         r_bytes    <= '0;
         r_shift    <= '0;
         r_rem      <= '0;
         r_color    <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_complete <= 1'b0;
         r_ovf      <= 1'b0;
         r_short    <= 1'b0;
      end else begin
         r_wr_en <= w_wr;
         if (w_wr) begin
            r_wr_addr <= r_cnt[ADDR_W-1:0];
            r_wr_data <= w_px;
         end
         if (bus.in_start) begin
            r_cnt      <= '0;
            r_bytes    <= w_push ? (ADDR_W+1)'(1) : '0;
            r_rem      <= '0;
            r_complete <= 1'b0;
            r_ovf      <= 1'b0;
            r_short    <= 1'b0;
         end else begin
            if (w_wr)    r_cnt   <= r_cnt + (ADDR_W+1)'(1);
            if (w_push)  r_bytes <= r_bytes + (ADDR_W+1)'(1);
            if (w_drop)  r_ovf   <= 1'b1;
            if (w_enter_clear) begin
               r_cnt   <= '0;
               r_color <= bus.clear_color;
            end
            if (w_pop) begin
               r_shift <= w_dout[SH_W-1:0];
               r_rem   <= REM_INIT;
            end else if (r_rem != '0) begin
               r_shift <= r_shift << PIX_W;
               r_rem   <= r_rem - 2'd1;
            end
            if (w_to_done) begin
               r_complete <= (r_cnt == CNT_FULL);
               r_short    <= (r_cnt != CNT_FULL);
            end
         end
      end
   end

   assign bus.wr_en          = r_wr_en;
   assign bus.wr_addr        = r_wr_addr;
   assign bus.wr_data        = r_wr_data;
   assign bus.busy           = (r_state == ST_LOAD) || (r_state == ST_DRAIN) || (r_state == ST_CLEAR);
   assign bus.image_complete = r_complete;
   assign bus.overflow_err   = r_ovf;
   assign bus.short_err      = r_short;
endmodule

// File: tb/tb_fb_write_ctrl.sv
// Self-checking bench for fb_write_ctrl against a queue-based byte/pixel reference model.
module tb_fb_write_ctrl;
   localparam int NPIX  = 32768;
   localparam int DEPTH = 4;
   localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2, M_CLEAR = 3, M_DONE = 4;

   typedef struct packed {
      logic [14:0] addr;
      logic [1:0]  data;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   int   nprint = 0;

   wr_t        obs[$];
   logic [7:0] mq[$];
   logic [1:0] exp_px[$];
   int         m_wait, m_bytes, m_mode;
   bit         m_ovf;

   fb_write_ctrl_if bus ();

   fb_write_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset_n && bus.wr_en === 1'b1) obs.push_back(wr_t'{bus.wr_addr, bus.wr_data});
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: FIFO occupancy, one byte unpacked per 4 cycles, byte limit per frame.
   task automatic model_cycle(input bit v, input logic [7:0] d, input bit st, input bit en, input bit cr);
      bit         do_pop;
      logic [7:0] b;
      if (st) begin
         mq.delete(); exp_px.delete();
         m_wait = 0; m_bytes = 0; m_ovf = 0; m_mode = M_LOAD;
         if (v) begin mq.push_back(d); m_bytes = 1; end
      end else if (m_mode == M_LOAD || m_mode == M_DRAIN) begin
         do_pop = (m_wait == 0) && (mq.size() != 0);
         if (m_wait != 0) m_wait--;
         if (m_mode == M_LOAD && v) begin
            if (mq.size() < DEPTH && m_bytes < NPIX / 4) begin mq.push_back(d); m_bytes++; end
            else m_ovf = 1;
         end
         if (do_pop) begin
            b = mq.pop_front();
            for (int k = 0; k < 4; k++) exp_px.push_back(b[7-2*k -: 2]);
            m_wait = 3;
         end
         if (m_mode == M_LOAD && en) m_mode = M_DRAIN;
      end else if ((m_mode == M_IDLE || m_mode == M_DONE) && cr) begin
         m_mode = M_CLEAR;
      end
   endtask

   task automatic step(input bit v, input logic [7:0] d, input bit st, input bit en,
                       input bit cr, input logic [1:0] cc);
      bus.in_valid = v; bus.in_data = d; bus.in_start = st;
      bus.in_end = en; bus.clear_req = cr; bus.clear_color = cc;
      model_cycle(v, d, st, en, cr);
      @(posedge clk); #1;
      if (st) obs.delete();
      bus.in_valid = 0; bus.in_start = 0; bus.in_end = 0; bus.clear_req = 0;
   endtask

   task automatic step_idle();
      step(0, 8'h00, 0, 0, 0, 2'd0);
   endtask

   task automatic test_reset();
      reset_n = 0;
      bus.in_valid = 0; bus.in_data = 0; bus.in_start = 0;
      bus.in_end = 0; bus.clear_req = 0; bus.clear_color = 0;
      m_mode = M_IDLE; m_wait = 0; m_bytes = 0; m_ovf = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.wr_en, bus.busy, bus.image_complete, bus.overflow_err, bus.short_err} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: actual=%b required=00000",
            {bus.wr_en, bus.busy, bus.image_complete, bus.overflow_err, bus.short_err});
      end
      checks++;
      if (bus.wr_addr !== 15'd0 || bus.wr_data !== 2'd0) begin
         errors++; $display("FAIL reset_bus: actual addr=%0h data=%0d required 0/0", bus.wr_addr, bus.wr_data);
      end
      @(negedge clk) reset_n = 1;
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
         errors++; $display("FAIL reset_release: actual busy=%b wr_en=%b required 0/0", bus.busy, bus.wr_en);
      end
   endtask

   task automatic test_clear();
      int bad = 0;
      step(0, 8'h00, 0, 0, 1, 2'd2);
      for (int i = 0; i < NPIX; i++) begin
         step_idle();
         checks++;
         if (bus.wr_en !== 1'b1 || bus.wr_addr !== 15'(i) || bus.wr_data !== 2'd2 || bus.busy !== 1'b1) begin
            errors++; bad++;
            if (bad < 8) $display("FAIL clear_write %0d: actual en=%b addr=%0h data=%0d busy=%b required 1/%0h/2/1",
               i, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, i);
         end
      end
      step_idle();
      m_mode = M_IDLE;
      checks++;
      if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0 || bus.image_complete !== 1'b0) begin
         errors++; $display("FAIL clear_end: actual busy=%b wr_en=%b complete=%b required 0/0/0",
            bus.busy, bus.wr_en, bus.image_complete);
      end
   endtask

   task automatic test_short();
      step(0, 8'h00, 1, 0, 0, 2'd0);
      for (int i = 0; i < 2; i++) begin
         step(1, 8'h1B, 0, 0, 0, 2'd0);
         repeat ($urandom_range(0, 5)) step_idle();
      end
      step(0, 8'h00, 0, 1, 0, 2'd0);
      for (int n = 0; n < 200 && bus.busy; n++) step_idle();
      m_mode = M_DONE;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL short_done: busy actual=%b required=0", bus.busy); end
      checks++;
      if (obs.size() != exp_px.size()) begin
         errors++; $display("FAIL short_count: actual=%0d required=%0d", obs.size(), exp_px.size());
      end
      foreach (exp_px[i]) if (i < obs.size()) begin
         checks++;
         if (obs[i].addr !== 15'(i) || obs[i].data !== exp_px[i]) begin
            errors++; if (nprint++ < 10) $display("FAIL short_px %0d: actual addr=%0h data=%0d required %0h/%0d",
               i, obs[i].addr, obs[i].data, i, exp_px[i]);
         end
      end
      checks++;
      if ({bus.image_complete, bus.short_err, bus.overflow_err} !== {exp_px.size() == NPIX, exp_px.size() != NPIX, m_ovf}) begin
         errors++; $display("FAIL short_flags: actual c/s/o=%b%b%b required %b%b%b", bus.image_complete,
            bus.short_err, bus.overflow_err, exp_px.size() == NPIX, exp_px.size() != NPIX, m_ovf);
      end
   endtask

   task automatic test_back_to_back();
      step(0, 8'h00, 1, 0, 0, 2'd0);
      for (int i = 0; i < 6; i++) step(1, 8'($urandom), 0, 0, 0, 2'd0);
      step(0, 8'h00, 0, 1, 0, 2'd0);
      for (int n = 0; n < 200 && bus.busy; n++) step_idle();
      m_mode = M_DONE;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL burst_done: busy actual=%b required=0", bus.busy); end
      checks++;
      if (obs.size() != exp_px.size()) begin
         errors++; $display("FAIL burst_count: actual=%0d required=%0d", obs.size(), exp_px.size());
      end
      foreach (exp_px[i]) if (i < obs.size()) begin
         checks++;
         if (obs[i].addr !== 15'(i) || obs[i].data !== exp_px[i]) begin
            errors++; if (nprint++ < 10) $display("FAIL burst_px %0d: actual addr=%0h data=%0d required %0h/%0d",
               i, obs[i].addr, obs[i].data, i, exp_px[i]);
         end
      end
      checks++;
      if (bus.overflow_err !== m_ovf || bus.short_err !== 1'b1) begin
         errors++; $display("FAIL burst_flags: actual ovf=%b short=%b required %b/1", bus.overflow_err, bus.short_err, m_ovf);
      end
   endtask

   task automatic test_full_frame();
      step(0, 8'h00, 1, 0, 0, 2'd0);
      for (int i = 0; i < NPIX / 4; i++) begin
         step(1, 8'hE4, 0, 0, 0, 2'd0);
         repeat (3) step_idle();
      end
      checks++;
      if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL full_no_ovf: actual=%b required=0", bus.overflow_err); end
      for (int i = 0; i < 3; i++) begin
         step(1, 8'($urandom), 0, 0, 0, 2'd0);
         repeat (3) step_idle();
      end
      step(0, 8'h00, 0, 1, 0, 2'd0);
      for (int n = 0; n < 200 && bus.busy; n++) step_idle();
      m_mode = M_DONE;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL full_done: busy actual=%b required=0", bus.busy); end
      checks++;
      if (obs.size() != exp_px.size()) begin
         errors++; $display("FAIL full_count: actual=%0d required=%0d", obs.size(), exp_px.size());
      end
      foreach (exp_px[i]) if (i < obs.size()) begin
         checks++;
         if (obs[i].addr !== 15'(i) || obs[i].data !== exp_px[i]) begin
            errors++; if (nprint++ < 10) $display("FAIL full_px %0d: actual addr=%0h data=%0d required %0h/%0d",
               i, obs[i].addr, obs[i].data, i, exp_px[i]);
         end
      end
      checks++;
      if (obs.size() == 0 || obs[obs.size()-1].addr !== 15'h7FFF) begin
         errors++; $display("FAIL full_last_addr: actual=%0h required=7fff", obs.size() ? obs[obs.size()-1].addr : 15'h0);
      end
      checks++;
      if ({bus.image_complete, bus.short_err, bus.overflow_err} !== {exp_px.size() == NPIX, exp_px.size() != NPIX, m_ovf}) begin
         errors++; $display("FAIL full_flags: actual c/s/o=%b%b%b required %b%b%b", bus.image_complete,
            bus.short_err, bus.overflow_err, exp_px.size() == NPIX, exp_px.size() != NPIX, m_ovf);
      end
   endtask

   task automatic test_restart();
      // abort a clear partway, then restart a LOAD mid-byte
      step(0, 8'h00, 0, 0, 1, 2'($urandom_range(0, 3)));
      repeat (100) step_idle();
      step(1, 8'($urandom), 1, 0, 0, 2'd0);
      repeat (3) step_idle();
      step(1, 8'($urandom), 0, 1, 0, 2'd0);
      for (int n = 0; n < 200 && bus.busy; n++) step_idle();
      m_mode = M_DONE;
      checks++;
      if (obs.size() != exp_px.size() || exp_px.size() == 0) begin
         errors++; $display("FAIL abort_count: actual=%0d required=%0d", obs.size(), exp_px.size());
      end
      foreach (exp_px[i]) if (i < obs.size()) begin
         checks++;
         if (obs[i].addr !== 15'(i) || obs[i].data !== exp_px[i]) begin
            errors++; if (nprint++ < 10) $display("FAIL abort_px %0d: actual addr=%0h data=%0d required %0h/%0d",
               i, obs[i].addr, obs[i].data, i, exp_px[i]);
         end
      end
      step(0, 8'h00, 1, 0, 0, 2'd0);
      step(1, 8'($urandom), 0, 0, 0, 2'd0);
      step(1, 8'($urandom), 0, 0, 0, 2'd0);
      step_idle();
      step(1, 8'($urandom), 1, 0, 0, 2'd0);
      repeat (2) step_idle();
      step(0, 8'h00, 0, 1, 0, 2'd0);
      for (int n = 0; n < 200 && bus.busy; n++) step_idle();
      m_mode = M_DONE;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL restart_done: busy actual=%b required=0", bus.busy); end
      checks++;
      if (obs.size() != exp_px.size()) begin
         errors++; $display("FAIL restart_count: actual=%0d required=%0d", obs.size(), exp_px.size());
      end
      foreach (exp_px[i]) if (i < obs.size()) begin
         checks++;
         if (obs[i].addr !== 15'(i) || obs[i].data !== exp_px[i]) begin
            errors++; if (nprint++ < 10) $display("FAIL restart_px %0d: actual addr=%0h data=%0d required %0h/%0d",
               i, obs[i].addr, obs[i].data, i, exp_px[i]);
         end
      end
      checks++;
      if (bus.short_err !== 1'b1 || bus.overflow_err !== m_ovf) begin
         errors++; $display("FAIL restart_flags: actual short=%b ovf=%b required 1/%b", bus.short_err, bus.overflow_err, m_ovf);
      end
   endtask

   task automatic test_reset_mid();
      step(0, 8'h00, 1, 0, 0, 2'd0);
      step(1, 8'($urandom), 0, 0, 0, 2'd0);
      step_idle();
      @(negedge clk) reset_n = 0;
      #1;
      checks++;
      if ({bus.wr_en, bus.busy, bus.image_complete, bus.overflow_err, bus.short_err} !== 5'b0) begin
         errors++; $display("FAIL reset_mid: actual=%b required=00000",
            {bus.wr_en, bus.busy, bus.image_complete, bus.overflow_err, bus.short_err});
      end
      @(negedge clk) reset_n = 1;
      m_mode = M_IDLE;
      step_idle();
      checks++;
      if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
         errors++; $display("FAIL reset_mid_after: actual busy=%b wr_en=%b required 0/0", bus.busy, bus.wr_en);
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_short();
      test_back_to_back();
      test_full_frame();
      test_restart();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
